uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter PARITY_ODD, default 0, which selects parity sense when parity is compiled in: 0 = even, 1 = odd.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have port clk_bps, input, 1 bit: one-cycle pulse at each bit centre, from the external baud generator.
REQ-006 SHALL have port bps_start, output, 1 bit: run request to the baud generator.
REQ-007 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a byte is received with a good stop bit.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port parity_err, output, 1 bit: parity mismatch flag, coincident with the rx_valid or frame_err pulse.
REQ-011 SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (rx_s), preset to 1 on reset.
REQ-013 SHALL detect a start edge when rx_s is 1 on the previous cycle and 0 on the current cycle (falling edge).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (present only with the macro) and STOP, with frame order LSB-first: start bit, 8 data bits, optional parity bit, 1 stop bit.
REQ-015 IDLE: on a start edge, SHALL go to START and assert bps_start on the next cycle; clk_bps SHALL be ignored in IDLE.
REQ-016 START: on clk_bps, SHALL sample rx_s; if rx_s = 1 (false start), SHALL return to IDLE and drop bps_start; otherwise SHALL go to DATA with the bit counter at 0.
REQ-017 DATA: on each clk_bps, SHALL write rx_s into shift bit[cnt] and increment the 3-bit counter; after the 8th sample (cnt wraps 7->0) SHALL go to PARITY if compiled in, otherwise to STOP.
REQ-018 PARITY: on clk_bps, SHALL sample the parity bit, compute the mismatch as XOR(data, parity bit, PARITY_ODD) != 0, and go to STOP.
REQ-019 STOP: on clk_bps, SHALL load rx_data from the shift register, go to IDLE and drop bps_start, with outputs on the following cycle:
  - stop = 1: rx_valid pulses for 1 cycle.
  - stop = 0: frame_err pulses for 1 cycle; rx_data still updated; rx_valid stays low.
REQ-020 SHALL drive parity_err during that same cycle and low at all other times.
REQ-021 Latency SHALL be one clk cycle from the clk_bps in STOP to rx_valid/frame_err.
REQ-022 rx_data SHALL hold its value until the next completed frame.
REQ-023 After a frame error with rx held low (break), SHALL remain in IDLE until rx_s returns high and a new falling edge occurs.
REQ-024 A start edge arriving on the same cycle as the STOP-state clk_bps SHALL be ignored.
REQ-025 A start edge arriving one or more cycles after the return to IDLE SHALL be accepted, permitting back-to-back frames.
REQ-026 The receiver SHALL ignore rx edges whenever the state is not IDLE.

Reset
REQ-027 On rst, SHALL set state = IDLE, bps_start = 0, rx_data = 8'h00, rx_valid = 0, frame_err = 0, parity_err = 0, rx_busy = 0, and both synchronizer flops and the edge-history flop = 1.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse.
REQ-029 After a mid-frame reset, reception SHALL restart only on a fresh falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN, when defined, SHALL include the PARITY state and parity check, giving 11-bit frames.
REQ-031 When UART_RX_PARITY_EN is not defined, the block SHALL have no PARITY state, parity_err SHALL be tied to 0, PARITY_ODD SHALL have no effect, and frames SHALL be 10 bits.

Verification
REQ-032 Send 0xA5 with stop = 1 and no parity -> rx_data = 0xA5, rx_valid high for exactly 1 cycle, frame_err = 0, bps_start low afterwards.
REQ-033 Pulse rx low for 3 cycles, then high before the START clk_bps -> return to IDLE, no rx_valid, bps_start deasserted.
REQ-034 Send 0x3C with stop = 0 -> frame_err pulses once, rx_data = 0x3C, rx_valid = 0; hold rx low for 2 bit times -> no new frame starts.
REQ-035 With UART_RX_PARITY_EN, PARITY_ODD = 0, send 0x07 with parity bit 1 -> rx_valid = 1, parity_err = 0; resend with parity bit 0 -> rx_valid = 1, parity_err = 1.
REQ-036 Assert rst during data bit 4 of a frame, then send 0x55 -> no pulse from the aborted frame, then rx_data = 0x55 with rx_valid.
REQ-037 Send 0x00 then 0xFF back-to-back (the next start bit begins immediately after the stop bit) -> two rx_valid pulses with rx_data = 0x00, then rx_data = 0xFF.

Source files
------------

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- result bus of the UART receiver.
//
// Signals:
//   rx_data    [7:0] last received byte (held until the next completed frame)
//   rx_valid         one-cycle pulse: byte received with a good stop bit
//   frame_err        one-cycle pulse: stop bit sampled low
//   parity_err       parity mismatch, only ever high together with
//                    rx_valid or frame_err
//   rx_busy          high whenever the receiver FSM is not IDLE
//   state_dbg  [2:0] raw FSM state encoding, for checkers and waveforms
//
// Handshake: there is no back-pressure. rx_valid / frame_err are
// single-cycle strobes that the consumer must capture in the cycle they are
// high; rx_data and parity_err are qualified by those strobes.
//
// Modports: master = the receiver (drives everything), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;
  logic [2:0] state_dbg;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output rx_busy,
    output state_dbg
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input rx_busy,
    input state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8-bit UART receiver driven by an external baud generator.
//
// Frame (LSB first): start bit, 8 data bits, optional parity bit, 1 stop bit.
// The external generator is started by bps_start and returns clk_bps, a
// one-cycle pulse at the centre of each bit.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   rx         in   asynchronous serial line, idle high
//   clk_bps    in   bit-centre pulse from the baud generator
//   bps_start  out  run request to the baud generator
//   bus        uart_rx_if.master  rx_data / rx_valid / frame_err /
//                                 parity_err / rx_busy / state_dbg
//
// Parameter:
//   PARITY_ODD  parity sense when parity is compiled in (0 even, 1 odd)
//
// Build option:
//   UART_RX_PARITY_EN  when defined, adds the PARITY state and parity check
//                      (11-bit frames); otherwise parity_err is tied low and
//                      frames are 10 bits.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  input  logic      clk_bps,
  output logic      bps_start,
  uart_rx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       rx_meta;
  logic       rx_s;
  logic       rx_prev;
  logic       start_edge;

  logic [7:0] shift;
  logic [2:0] cnt;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       frame_err_q;

  // Synchronizer and edge-history flops all preset to the idle level so a
  // reset never manufactures a falling edge on an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Edges are only looked at in IDLE, and clk_bps only
  // outside IDLE; this is what makes an edge coincident with the STOP sample
  // invisible and keeps a held-low break line from re-triggering.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_edge) state_next = START;
      end
      START: begin
        if (clk_bps) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (clk_bps && (cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_bps) state_next = STOP;
      end
`endif
      STOP: begin
        if (clk_bps) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. bps_start follows the next state so it rises the cycle after
  // the start edge and falls together with the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bps_start   <= 1'b0;
      shift       <= 8'h00;
      cnt         <= 3'd0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bps_start   <= (state_next != IDLE);
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (clk_bps) begin
        case (state)
          START: cnt <= 3'd0;
          DATA: begin
            shift[cnt] <= rx_s;
            cnt        <= cnt + 3'd1;
          end
          STOP: begin
            rx_data_q   <= shift;
            rx_valid_q  <= rx_s;
            frame_err_q <= ~rx_s;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err_q;

  // par_bad is captured in PARITY and only published with the STOP strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      if (clk_bps && (state == PARITY)) begin
        par_bad <= (^shift) ^ rx_s ^ (PARITY_ODD != 0);
      end
      if (clk_bps && (state == STOP)) begin
        parity_err_q <= par_bad;
      end
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  // PARITY_ODD has no effect without the parity stage; it is referenced
  // here only so the constant-zero tie does not leave it dangling.
  assign bus.parity_err = (PARITY_ODD != 0) && 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = (state != IDLE);
  assign bus.state_dbg = state;

endmodule
